// File: rtl/alu_ctrl.sv
//============================================================================
// Module   : alu_ctrl
// Brief    : Multi-cycle execute sequencer for the CPU ALU. Accepts one
//            16-bit instruction per valid/ready handshake, sequences
//            DECODE / EXEC / WB, writes results back to the register file,
//            maintains the {V,C,N,Z} status register and resolves
//            conditional branches against it.
// Optional : ALU_CTRL_TRAP_EN - adds a TRAP state entered after an ADD/SUB
//            that overflows, plus the trap / trap_clr ports.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module alu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [3:0]  rf_raddr_a,
    output logic [3:0]  rf_raddr_b,
    output logic [3:0]  fs,
    input  logic [15:0] alu_result,
    input  logic        alu_c,
    input  logic        alu_v,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic [3:0]  status,
    output logic        pc_load,
    output logic [15:0] pc_offset,
`ifdef ALU_CTRL_TRAP_EN
    output logic        illegal,
    output logic        trap,
    input  logic        trap_clr
`else
    output logic        illegal
`endif
);

    // ------------------------------------------------------------------
    // Opcode and condition-code constants
    // ------------------------------------------------------------------
    localparam logic [3:0] c_op_cmp      = 4'h8;
    localparam logic [3:0] c_op_br       = 4'h9;
    localparam logic [3:0] c_op_nop      = 4'hA;
`ifdef ALU_CTRL_TRAP_EN
    localparam logic [3:0] c_op_add      = 4'h0;
    localparam logic [3:0] c_op_sub      = 4'h1;
`endif
    localparam logic [3:0] c_fs_sub      = 4'h1;
    localparam logic [3:0] c_fs_idle     = 4'h0;

    localparam logic [3:0] c_cond_always = 4'h0;
    localparam logic [3:0] c_cond_z      = 4'h1;
    localparam logic [3:0] c_cond_nz     = 4'h2;
    localparam logic [3:0] c_cond_n      = 4'h3;
    localparam logic [3:0] c_cond_nn     = 4'h4;
    localparam logic [3:0] c_cond_c      = 4'h5;
    localparam logic [3:0] c_cond_v      = 4'h6;

    // Status register bit positions within {V,C,N,Z}
    localparam int c_st_z = 0;
    localparam int c_st_n = 1;
    localparam int c_st_c = 2;
    localparam int c_st_v = 3;

    // ------------------------------------------------------------------
    // Sequencer states
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
`ifdef ALU_CTRL_TRAP_EN
        S_WB     = 3'd3,
        S_TRAP   = 3'd4
`else
        S_WB     = 3'd3
`endif
    } state_t;

    state_t      state_q,     state_d;
    logic [15:0] instr_q,     instr_d;
    logic [15:0] result_q,    result_d;
    logic        cap_c_q,     cap_c_d;
    logic        cap_v_q,     cap_v_d;
    logic        rf_we_q,     rf_we_d;
    logic [3:0]  rf_waddr_q,  rf_waddr_d;
    logic [15:0] rf_wdata_q,  rf_wdata_d;
    logic [3:0]  status_q,    status_d;
    logic        pc_load_q,   pc_load_d;
    logic [15:0] pc_offset_q, pc_offset_d;
    logic        illegal_q,   illegal_d;
`ifdef ALU_CTRL_TRAP_EN
    logic        trap_q,      trap_d;
`endif

    // Fields of the latched instruction
    logic [3:0] opcode;
    logic [3:0] rd_cond;
    logic [3:0] ra;
    logic [3:0] rb;
    logic       is_alu_op;
    logic       is_cmp;
    logic       is_br;
    logic       branch_taken;

    assign opcode    = instr_q[15:12];
    assign rd_cond   = instr_q[11:8];
    assign ra        = instr_q[7:4];
    assign rb        = instr_q[3:0];
    assign is_alu_op = ~opcode[3];
    assign is_cmp    = (opcode == c_op_cmp);
    assign is_br     = (opcode == c_op_br);

    // Branch condition evaluated against the architectural status register
    always_comb begin
        branch_taken = 1'b0;
        case (rd_cond)
            c_cond_always: branch_taken = 1'b1;
            c_cond_z:      branch_taken = status_q[c_st_z];
            c_cond_nz:     branch_taken = ~status_q[c_st_z];
            c_cond_n:      branch_taken = status_q[c_st_n];
            c_cond_nn:     branch_taken = ~status_q[c_st_n];
            c_cond_c:      branch_taken = status_q[c_st_c];
            c_cond_v:      branch_taken = status_q[c_st_v];
            default:       branch_taken = 1'b0;
        endcase
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        result_d    = result_q;
        cap_c_d     = cap_c_q;
        cap_v_d     = cap_v_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        status_d    = status_q;
        pc_load_d   = 1'b0;
        pc_offset_d = pc_offset_q;
        illegal_d   = 1'b0;
`ifdef ALU_CTRL_TRAP_EN
        trap_d      = trap_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = S_DECODE;
                    // Registered pulse must be visible during DECODE, so it
                    // is decided from the incoming opcode at the handshake.
                    illegal_d = (instr[15:12] > c_op_nop);
                end
            end

            S_DECODE: begin
                if (is_alu_op || is_cmp || is_br) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_IDLE;
                end
                // pc_load is registered yet must be high during EXEC; status
                // cannot change between DECODE and EXEC of a branch, so the
                // decision taken here equals the EXEC-cycle view of status.
                if (is_br && branch_taken) begin
                    pc_load_d   = 1'b1;
                    pc_offset_d = {{8{instr_q[7]}}, instr_q[7:0]};
                end
            end

            S_EXEC: begin
                if (is_br) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = alu_result;
                    cap_c_d  = alu_c;
                    cap_v_d  = alu_v;
                    state_d  = S_WB;
                    // Write strobe registered here so it occupies the WB cycle
                    if (is_alu_op) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = rd_cond;
                        rf_wdata_d = alu_result;
                    end
                end
            end

            S_WB: begin
                status_d = {cap_v_q, cap_c_q, result_q[15], (result_q == 16'h0000)};
                state_d  = S_IDLE;
`ifdef ALU_CTRL_TRAP_EN
                if (((opcode == c_op_add) || (opcode == c_op_sub)) && cap_v_q) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                end
`endif
            end

`ifdef ALU_CTRL_TRAP_EN
            S_TRAP: begin
                if (trap_clr) begin
                    trap_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            instr_q     <= 16'h0000;
            result_q    <= 16'h0000;
            cap_c_q     <= 1'b0;
            cap_v_q     <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= 4'h0;
            rf_wdata_q  <= 16'h0000;
            status_q    <= 4'b0000;
            pc_load_q   <= 1'b0;
            pc_offset_q <= 16'h0000;
            illegal_q   <= 1'b0;
`ifdef ALU_CTRL_TRAP_EN
            trap_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            result_q    <= result_d;
            cap_c_q     <= cap_c_d;
            cap_v_q     <= cap_v_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            status_q    <= status_d;
            pc_load_q   <= pc_load_d;
            pc_offset_q <= pc_offset_d;
            illegal_q   <= illegal_d;
`ifdef ALU_CTRL_TRAP_EN
            trap_q      <= trap_d;
`endif
        end
    end

    // Decoded outputs: handshake, ALU select and register read addresses
    always_comb begin
        instr_ready = (state_q == S_IDLE);
        fs          = c_fs_idle;
        rf_raddr_a  = 4'h0;
        rf_raddr_b  = 4'h0;
        if ((state_q == S_DECODE) || (state_q == S_EXEC)) begin
            rf_raddr_a = ra;
            rf_raddr_b = rb;
        end
        if (state_q == S_EXEC) begin
            if (is_alu_op) begin
                fs = opcode;
            end else if (is_cmp) begin
                fs = c_fs_sub;
            end
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign status    = status_q;
    assign pc_load   = pc_load_q;
    assign pc_offset = pc_offset_q;
    assign illegal   = illegal_q;
`ifdef ALU_CTRL_TRAP_EN
    assign trap      = trap_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl.sv
//============================================================================
// Module   : tb_alu_ctrl
// Brief    : Self-checking bench for alu_ctrl. The bench plays register
//            file and ALU, and compares every cycle of each instruction
//            against an instruction-level reference model.
// Optional : ALU_CTRL_TRAP_EN - also exercises the overflow trap.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_alu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  rf_raddr_a;
    logic [3:0]  rf_raddr_b;
    logic [3:0]  fs;
    logic [15:0] alu_result;
    logic        alu_c;
    logic        alu_v;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [3:0]  status;
    logic        pc_load;
    logic [15:0] pc_offset;
    logic        illegal;
`ifdef ALU_CTRL_TRAP_EN
    logic        trap;
    logic        trap_clr;
`endif

    alu_ctrl u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .rf_raddr_a  (rf_raddr_a),
        .rf_raddr_b  (rf_raddr_b),
        .fs          (fs),
        .alu_result  (alu_result),
        .alu_c       (alu_c),
        .alu_v       (alu_v),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .status      (status),
        .pc_load     (pc_load),
        .pc_offset   (pc_offset),
`ifdef ALU_CTRL_TRAP_EN
        .illegal     (illegal),
        .trap        (trap),
        .trap_clr    (trap_clr)
`else
        .illegal     (illegal)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Single comparison point for the whole bench
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ALU behaviour as seen by the sequencer: {V, C, F}
    function automatic logic [17:0] alu_fn(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic        c;
        logic        v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (f)
            4'h0: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16];
                        v = (a[15] == b[15]) && (r[15] != a[15]); end
            4'h1: begin r = a - b; c = (a >= b); v = (a[15] != b[15]) && (r[15] != a[15]); end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: r = ~a;
            4'h6: begin r = {a[14:0], 1'b0}; c = a[15]; v = a[15] ^ a[14]; end
            4'h7: begin r = {a[15], a[15:1]}; c = a[0]; end
            default: ;
        endcase
        return {v, c, r};
    endfunction

    // Datapath register file driven by the DUT (plus a bench preload port)
    logic [15:0] tb_rf [16];
    logic        pl_we = 1'b0;
    logic [3:0]  pl_addr = 4'h0;
    logic [15:0] pl_data = 16'h0;
    logic [17:0] alu_out;

    always @(posedge clk) begin
        if (pl_we)      tb_rf[pl_addr]  <= pl_data;
        else if (rf_we) tb_rf[rf_waddr] <= rf_wdata;
    end

    assign alu_out    = alu_fn(fs, tb_rf[rf_raddr_a], tb_rf[rf_raddr_b]);
    assign alu_result = alu_out[15:0];
    assign alu_c      = alu_out[16];
    assign alu_v      = alu_out[17];

    // Reference model state
    logic [15:0] ref_rf [16];
    logic ref_v = 1'b0, ref_c = 1'b0, ref_n = 1'b0, ref_z = 1'b0;

    task automatic load_reg(input logic [3:0] a, input logic [15:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
        ref_rf[a] = d;
    endtask

    // Issue one instruction and check every cycle until it retires
    task automatic issue(input logic [15:0] ins, input bit hold, input logic [15:0] nxt);
        logic [3:0]  op, rd, ra, rb;
        logic [17:0] r;
        logic [3:0]  old_st, new_st, exp_fs;
        bit          is_alu, is_cmp, is_br, is_ill, taken, trap_exp, updates;
        int          rdy_cyc, n;
        op = ins[15:12]; rd = ins[11:8]; ra = ins[7:4]; rb = ins[3:0];
        is_alu = (op <= 4'h7);
        is_cmp = (op == 4'h8);
        is_br  = (op == 4'h9);
        is_ill = (op >= 4'hB);
        updates = is_alu || is_cmp;
        r = '0;
        if (updates) r = alu_fn(is_cmp ? 4'h1 : op, ref_rf[ra], ref_rf[rb]);
        case (rd)
            4'h0: taken = 1'b1;
            4'h1: taken = ref_z;
            4'h2: taken = !ref_z;
            4'h3: taken = ref_n;
            4'h4: taken = !ref_n;
            4'h5: taken = ref_c;
            4'h6: taken = ref_v;
            default: taken = 1'b0;
        endcase
        taken  = taken && is_br;
        old_st = {ref_v, ref_c, ref_n, ref_z};
        new_st = updates ? {r[17], r[16], r[15], (r[15:0] == 16'h0)} : old_st;
        exp_fs = is_alu ? op : (is_cmp ? 4'h1 : 4'h0);
        rdy_cyc = updates ? 4 : (is_br ? 3 : 2);
        trap_exp = 1'b0;
`ifdef ALU_CTRL_TRAP_EN
        trap_exp = (op <= 4'h1) && r[17];
`endif
        n = 0;
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            check_eq("handshake_timeout", 32'd0, 32'd1);
            return;
        end
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= rdy_cyc; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (hold) instr = nxt;
                else      instr_valid = 1'b0;
                check_eq("raddr_a", rf_raddr_a, ra);
                check_eq("raddr_b", rf_raddr_b, rb);
                check_eq("fs_decode", fs, 0);
            end
            if (c == 2 && (updates || is_br)) begin
                check_eq("fs_exec", fs, exp_fs);
                check_eq("raddr_a_exec", rf_raddr_a, ra);
            end
            check_eq("instr_ready", instr_ready, (c == rdy_cyc) && !trap_exp);
            check_eq("rf_we", rf_we, is_alu && (c == 3));
            if (is_alu && c == 3) begin
                check_eq("rf_waddr", rf_waddr, rd);
                check_eq("rf_wdata", rf_wdata, r[15:0]);
            end
            check_eq("pc_load", pc_load, taken && (c == 2));
            if (taken && c == 2) check_eq("pc_offset", pc_offset, {{8{ins[7]}}, ins[7:0]});
            check_eq("illegal", illegal, is_ill && (c == 1));
            check_eq("status", status, (c == rdy_cyc) ? new_st : old_st);
`ifdef ALU_CTRL_TRAP_EN
            check_eq("trap", trap, trap_exp && (c == 4));
`endif
        end
        if (is_alu) ref_rf[rd] = r[15:0];
        {ref_v, ref_c, ref_n, ref_z} = new_st;
`ifdef ALU_CTRL_TRAP_EN
        if (trap_exp) begin
            trap_clr = 1'b1;
            @(negedge clk);
            trap_clr = 1'b0;
            check_eq("trap_cleared", trap, 0);
            check_eq("ready_after_trap", instr_ready, 1);
        end
`endif
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ri;
        rst_n = 1'b0;
        instr = 16'h0000;
        instr_valid = 1'b0;
`ifdef ALU_CTRL_TRAP_EN
        trap_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        // Reset values
        check_eq("rst_ready", instr_ready, 1);
        check_eq("rst_fs", fs, 0);
        check_eq("rst_raddr_a", rf_raddr_a, 0);
        check_eq("rst_raddr_b", rf_raddr_b, 0);
        check_eq("rst_rf_we", rf_we, 0);
        check_eq("rst_waddr", rf_waddr, 0);
        check_eq("rst_wdata", rf_wdata, 0);
        check_eq("rst_status", status, 0);
        check_eq("rst_pc_load", pc_load, 0);
        check_eq("rst_pc_offset", pc_offset, 0);
        check_eq("rst_illegal", illegal, 0);
`ifdef ALU_CTRL_TRAP_EN
        check_eq("rst_trap", trap, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) load_reg(i[3:0], 16'($urandom));

        // ADD with signed overflow
        load_reg(4'h1, 16'h7FFF);
        load_reg(4'h2, 16'h0001);
        issue(16'h0312, 1'b0, 16'h0);
        // CMP equal, then taken BR on Z
        load_reg(4'h4, 16'h1234);
        load_reg(4'h5, 16'h1234);
        issue(16'h8045, 1'b0, 16'h0);
        issue(16'h91FE, 1'b0, 16'h0);
        // Clear Z, then BR on Z not taken
        issue(16'h0645, 1'b0, 16'h0);
        issue(16'h9105, 1'b0, 16'h0);
        // Illegal and NOP
        issue(16'hB000, 1'b0, 16'h0);
        issue(16'hA123, 1'b0, 16'h0);
        // Back-pressure: valid held through an ADD
        issue(16'h0745, 1'b1, 16'h0845);
        issue(16'h0845, 1'b0, 16'h0);

        // Reset during EXEC of an ADD
        load_reg(4'h1, 16'h7FFF);
        load_reg(4'h2, 16'h0001);
        instr = 16'h0312;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_ready", instr_ready, 1);
        check_eq("midrst_rf_we", rf_we, 0);
        check_eq("midrst_status", status, 0);
        {ref_v, ref_c, ref_n, ref_z} = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("postrst_rf_we", rf_we, 0);
            check_eq("postrst_ready", instr_ready, 1);
        end
        check_eq("postrst_status", status, 0);

        // Randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            ri = 16'($urandom);
            if ((i % 5) == 0) ri[15:12] = 4'h9;
            issue(ri, 1'b0, 16'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
